// File: rtl/rb_seq.sv
// rtl/rb_seq.sv - command sequencer driving register bank rb (WRITE/READ/COPY/CLEAR)
// Optional RB_SEQ_INIT_CLEAR_EN: zero the whole bank after reset before the first command.
module rb_seq #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_a,
  input  logic [AW-1:0] cmd_b,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_d1,
  output logic [DW-1:0] rsp_d2,
  output logic          busy,
  output logic [AW-1:0] RR1,
  output logic [AW-1:0] RR2,
  output logic [AW-1:0] wR,
  output logic [DW-1:0] wD,
  output logic          RW,
  input  logic [DW-1:0] RD1,
  input  logic [DW-1:0] RD2
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    CP_RD = 3'd3,
    CP_WR = 3'd4,
    CLR   = 3'd5
  } state_t;

  localparam logic [1:0]    OP_WRITE = 2'd0;
  localparam logic [1:0]    OP_READ  = 2'd1;
  localparam logic [1:0]    OP_COPY  = 2'd2;
  localparam logic [1:0]    OP_CLEAR = 2'd3;
  localparam logic [AW-1:0] CNT_MAX  = '1;
  localparam logic [AW-1:0] CNT_ONE  = AW'(1);

  state_t        state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic [DW-1:0] tmp, tmp_n;
  logic [AW-1:0] cp_dst, cp_dst_n;
  logic [AW-1:0] rr1_n, rr2_n, wr_n;
  logic [DW-1:0] wd_n;
  logic          rw_n;
  logic          rsp_valid_n;
  logic [DW-1:0] rsp_d1_n, rsp_d2_n;
  logic          accept;

  assign cmd_ready = (state == IDLE) && !rsp_valid;
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // With the init-clear build the bank sweep starts straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef RB_SEQ_INIT_CLEAR_EN
      state <= CLR;
`else
      state <= IDLE;
`endif
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_WRITE: state_n = WR;
            OP_READ:  state_n = RD;
            OP_COPY:  state_n = CP_RD;
            OP_CLEAR: state_n = CLR;
            default:  state_n = IDLE;
          endcase
        end
      end
      WR:      state_n = IDLE;
      RD:      state_n = IDLE;
      CP_RD:   state_n = CP_WR;
      CP_WR:   state_n = IDLE;
      CLR:     state_n = (RW && (cnt == CNT_MAX)) ? IDLE : CLR;
      default: state_n = IDLE;
    endcase
  end

  // Next values of all registered outputs; RW is only raised for the cycle that writes.
  always_comb begin
    rw_n        = 1'b0;
    rr1_n       = RR1;
    rr2_n       = RR2;
    wr_n        = wR;
    wd_n        = wD;
    cnt_n       = cnt;
    tmp_n       = tmp;
    cp_dst_n    = cp_dst;
    rsp_valid_n = rsp_valid && !rsp_ready;
    rsp_d1_n    = rsp_d1;
    rsp_d2_n    = rsp_d2;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_WRITE: begin
              rw_n = 1'b1;
              wr_n = cmd_a;
              wd_n = cmd_data;
            end
            OP_READ: begin
              rr1_n = cmd_a;
              rr2_n = cmd_b;
            end
            OP_COPY: begin
              rr1_n    = cmd_a;
              cp_dst_n = cmd_b;
            end
            OP_CLEAR: begin
              rw_n  = 1'b1;
              wr_n  = '0;
              wd_n  = '0;
              cnt_n = '0;
            end
            default: begin
              rw_n = 1'b0;
            end
          endcase
        end
      end
      RD: begin
        rsp_valid_n = 1'b1;
        rsp_d1_n    = RD1;
        rsp_d2_n    = RD2;
      end
      CP_RD: begin
        tmp_n = RD1;
        rw_n  = 1'b1;
        wr_n  = cp_dst;
        wd_n  = RD1;
      end
      CLR: begin
        // RW low here only on the first cycle after an init-clear reset: write cnt without advancing.
        if (!RW) begin
          rw_n = 1'b1;
          wr_n = cnt;
          wd_n = '0;
        end else if (cnt == CNT_MAX) begin
          cnt_n = '0;
        end else begin
          rw_n  = 1'b1;
          cnt_n = cnt + CNT_ONE;
          wr_n  = cnt + CNT_ONE;
          wd_n  = '0;
        end
      end
      default: begin
        rw_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RW        <= 1'b0;
      RR1       <= '0;
      RR2       <= '0;
      wR        <= '0;
      wD        <= '0;
      cnt       <= '0;
      tmp       <= '0;
      cp_dst    <= '0;
      rsp_valid <= 1'b0;
      rsp_d1    <= '0;
      rsp_d2    <= '0;
    end else begin
      RW        <= rw_n;
      RR1       <= rr1_n;
      RR2       <= rr2_n;
      wR        <= wr_n;
      wD        <= wd_n;
      cnt       <= cnt_n;
      tmp       <= tmp_n;
      cp_dst    <= cp_dst_n;
      rsp_valid <= rsp_valid_n;
      rsp_d1    <= rsp_d1_n;
      rsp_d2    <= rsp_d2_n;
    end
  end

endmodule

// File: tb/tb_rb_seq.sv
// tb/tb_rb_seq.sv - scoreboard bench for rb_seq with a behavioural bank model
// Honours RB_SEQ_INIT_CLEAR_EN when the design is built with it.
module tb_rb_seq;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_a = '0;
  logic [AW-1:0] cmd_b = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_d1, rsp_d2;
  logic          busy;
  logic [AW-1:0] RR1, RR2, wR;
  logic [DW-1:0] wD;
  logic          RW;
  logic [DW-1:0] RD1, RD2;

  rb_seq #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_d1(rsp_d1), .rsp_d2(rsp_d2),
    .busy(busy), .RR1(RR1), .RR2(RR2), .wR(wR), .wD(wD), .RW(RW),
    .RD1(RD1), .RD2(RD2)
  );

  always #5 clk = ~clk;

  // Register bank stand-in: combinational read, write on the clock edge.
  logic [DW-1:0] mem [NR];
  logic          preload = 1'b0;
  logic [AW-1:0] pl_a = '0;
  logic [DW-1:0] pl_d = '0;
  assign RD1 = mem[RR1];
  assign RD2 = mem[RR2];
  always @(posedge clk) begin
    if (preload) mem[pl_a] <= pl_d;
    else if (RW) mem[wR] <= wD;
  end

  typedef struct packed { logic [DW-1:0] d1; logic [DW-1:0] d2; } rsp_t;
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  logic [DW-1:0] ref_m [NR];

  int n_checks = 0;
  int n_fail = 0;
  logic hold = 1'b0;
  logic wchk = 1'b1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  rsp_t mon_r;
  wr_t  mon_w;
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
      else begin
        mon_r = rsp_q.pop_front();
        check("rsp_d1", 64'(rsp_d1), 64'(mon_r.d1));
        check("rsp_d2", 64'(rsp_d2), 64'(mon_r.d2));
      end
    end
    if (rst_n && RW && wchk) begin
      if (wr_q.size() == 0) check("write_unexpected", 64'(wR), 64'hffff);
      else begin
        mon_w = wr_q.pop_front();
        check("write_addr", 64'(wR), 64'(mon_w.a));
        check("write_data", 64'(wD), 64'(mon_w.d));
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (!hold) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      ref_m[i] = '0;
      wr_q.push_back({AW'(i), {DW{1'b0}}});
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!cmd_ready && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [DW-1:0] d, input bit noise);
    int t = 0;
    wait_ready();
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_data = d;
    case (op)
      2'd0: begin ref_m[a] = d; wr_q.push_back({a, d}); end
      2'd1: rsp_q.push_back({ref_m[a], ref_m[b]});
      2'd2: begin wr_q.push_back({b, ref_m[a]}); ref_m[b] = ref_m[a]; end
      default: model_clear();
    endcase
    @(posedge clk);
    #1;
    if (noise) begin
      cmd_op = 2'd0; cmd_a = AW'($urandom); cmd_data = $urandom;
      while (busy && t < 100) begin
        @(posedge clk);
        #1;
        t++;
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] h1, h2, old9;
  int bc, rc, t;

  initial begin
    preload = 1'b1;
    for (int i = 0; i < NR; i++) begin
      pl_a = AW'(i);
      pl_d = $urandom;
      ref_m[i] = pl_d;
      @(posedge clk);
      #1;
    end
    preload = 1'b0;
    check("reset_RW", 64'(RW), 64'd0);
    check("reset_wR", 64'(wR), 64'd0);
    check("reset_wD", 64'(wD), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_d1", 64'(rsp_d1), 64'd0);
`ifdef RB_SEQ_INIT_CLEAR_EN
    check("reset_busy", 64'(busy), 64'd1);
    model_clear();
`else
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
`endif
    rst_n = 1'b1;

    issue(2'd0, 5'd3, 5'd0, 32'hAAAAAAAA, 1'b0);
    issue(2'd1, 5'd3, 5'd5, '0, 1'b0);

    // Response held off for five cycles.
    wait_ready();
    hold = 1'b1; rsp_ready = 1'b0;
    issue(2'd1, AW'($urandom), AW'($urandom), '0, 1'b0);
    t = 0;
    while (!rsp_valid && t < 10) begin @(posedge clk); #1; t++; end
    h1 = rsp_d1; h2 = rsp_d2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_rsp_d1", 64'(rsp_d1), 64'(h1));
      check("hold_rsp_d2", 64'(rsp_d2), 64'(h2));
      check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_rsp_valid", 64'(rsp_valid), 64'd0);
    check("release_cmd_ready", 64'(cmd_ready), 64'd1);
    hold = 1'b0;

    issue(2'd0, 5'd7, 5'd0, 32'hDEADBEEF, 1'b1);
    issue(2'd2, 5'd7, 5'd15, '0, 1'b1);
    issue(2'd1, 5'd15, 5'd7, '0, 1'b0);

    // CLEAR: count busy and write cycles while junk commands are offered.
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 2'd3;
    model_clear();
    @(posedge clk);
    #1;
    cmd_op = 2'd0; cmd_a = 5'd9; cmd_data = 32'h12345678;
    bc = 0; rc = 0;
    while (busy && bc < 100) begin
      bc++;
      if (RW) rc++;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("clear_busy_cycles", 64'(bc), 64'd32);
    check("clear_rw_cycles", 64'(rc), 64'd32);
    issue(2'd1, 5'd3, 5'd15, '0, 1'b0);

    for (int i = 0; i < 12; i++)
      issue(2'd0, AW'(i), '0, $urandom, 1'b0);

    // Abort a CLEAR with reset in its tenth write cycle.
    wait_ready();
    wchk = 1'b0;
    old9 = ref_m[9];
    cmd_valid = 1'b1; cmd_op = 2'd3;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort_wR_before", 64'(wR), 64'd9);
    rst_n = 1'b0;
    #1;
    check("abort_RW", 64'(RW), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 9; i++) ref_m[i] = '0;
    check("abort_mem8", 64'(mem[8]), 64'd0);
    check("abort_mem9", 64'(mem[9]), 64'(old9));
    repeat (2) @(posedge clk);
    #1;
    wchk = 1'b1;
`ifdef RB_SEQ_INIT_CLEAR_EN
    model_clear();
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
`ifdef RB_SEQ_INIT_CLEAR_EN
    check("post_reset_busy", 64'(busy), 64'd1);
    check("post_reset_cmd_ready", 64'(cmd_ready), 64'd0);
`else
    check("post_reset_busy", 64'(busy), 64'd0);
    check("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
`endif

    for (int i = 0; i < 80; i++) begin
      logic [1:0] op;
      op = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue(op, AW'($urandom), AW'($urandom), $urandom, bit'($urandom_range(0, 1)));
    end

    wait_ready();
    t = 0;
    while ((rsp_q.size() != 0 || rsp_valid) && t < 100) begin @(posedge clk); #1; t++; end
    repeat (3) @(posedge clk);
    #1;
    check("rsp_queue_empty", 64'(rsp_q.size()), 64'd0);
    check("write_queue_empty", 64'(wr_q.size()), 64'd0);
    for (int i = 0; i < NR; i++)
      check("bank_contents", 64'(mem[i]), 64'(ref_m[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
